// File: rtl/seg7_scan_capture.sv
// Passive monitor for the multiplexed 7-segment bus: captures stable digits, rebuilds 6-digit frames and the two countdowns.
// Define SEG7_CAP_ACTIVE_LOW_EN to decode common-anode (active-low) segment patterns.
module seg7_scan_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  seg7_sel,
    input  logic [6:0]  seg7_out,
    input  logic        clr_err,
    output logic [23:0] digits,
    output logic [6:0]  cnt1,
    output logic [6:0]  cnt2,
    output logic        frame_valid,
    output logic        err_seq,
    output logic        err_pat
);
    localparam logic [1:0] S_SYNC    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0] STAB_CAP = 8'(STABLE_CYC - 1);

    logic [2:0]  r_sel, r_sel_d;
    logic [6:0]  r_seg, r_seg_d;
    logic [7:0]  r_stab;
    logic [1:0]  r_state;
    logic [2:0]  r_exp;
    logic [23:0] r_work;
    logic [23:0] r_digits;
    logic [6:0]  r_cnt1, r_cnt2;
    logic        r_err_seq, r_err_pat;

    logic        w_changed;
    logic        w_capture;
    logic [6:0]  w_seg_pol;
    logic [3:0]  w_dec;

    function automatic logic [6:0] bcd_count(input logic [3:0] tens, input logic [3:0] ones);
        if (tens <= 4'd9 && ones <= 4'd9)
            return {3'b000, tens} * 7'd10 + {3'b000, ones};
        else if (tens == 4'hF && ones <= 4'd9)
            return {3'b000, ones};
        else
            return 7'h7F;
    endfunction

    // The counter only sits at STAB_CAP for one cycle, and the delayed copy
    // still holds the dwelled value even if the bus moves on that same cycle.
    assign w_changed = (r_sel != r_sel_d) || (r_seg != r_seg_d);
    assign w_capture = (r_stab == STAB_CAP);

`ifdef SEG7_CAP_ACTIVE_LOW_EN
    assign w_seg_pol = ~r_seg_d;
`else
    assign w_seg_pol = r_seg_d;
`endif

    always_comb begin
        w_dec = 4'hE;
        case (w_seg_pol)
            7'b1111110: w_dec = 4'd0;
            7'b0110000: w_dec = 4'd1;
            7'b1101101: w_dec = 4'd2;
            7'b1111001: w_dec = 4'd3;
            7'b0110011: w_dec = 4'd4;
            7'b1011011: w_dec = 4'd5;
            7'b1011111: w_dec = 4'd6;
            7'b1110000: w_dec = 4'd7;
            7'b1111111: w_dec = 4'd8;
            7'b1111011: w_dec = 4'd9;
            7'b0000000: w_dec = 4'hF;
            default:    w_dec = 4'hE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_seg   <= '0;
            r_sel_d <= '0;
            r_seg_d <= '0;
            r_stab  <= '0;
        end else begin
            r_sel   <= seg7_sel;
            r_seg   <= seg7_out;
            r_sel_d <= r_sel;
            r_seg_d <= r_seg;
            if (w_changed)
                r_stab <= '0;
            else if (r_stab != STAB_MAX)
                r_stab <= r_stab + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_SYNC;
            r_exp     <= '0;
            r_work    <= 24'hFFFFFF;
            r_digits  <= 24'hFFFFFF;
            r_cnt1    <= 7'h7F;
            r_cnt2    <= 7'h7F;
            r_err_seq <= 1'b0;
            r_err_pat <= 1'b0;
        end else begin
            // Clear first so a same-cycle set event below takes priority.
            if (clr_err) begin
                r_err_seq <= 1'b0;
                r_err_pat <= 1'b0;
            end
            if (w_capture && w_dec == 4'hE)
                r_err_pat <= 1'b1;
            if (r_state == S_PUBLISH)
                r_state <= S_SYNC;
            if (w_capture) begin
                if (r_sel_d[2:1] == 2'b11) begin
                    r_err_seq <= 1'b1;
                    r_state   <= S_SYNC;
                end else begin
                    case (r_state)
                        S_SYNC: if (r_sel_d == 3'd5) begin
                            r_work[23:20] <= w_dec;
                            r_exp         <= 3'd4;
                            r_state       <= S_SCAN;
                        end
                        S_SCAN: if (r_sel_d == r_exp) begin
                            r_work[4*r_sel_d +: 4] <= w_dec;
                            if (r_sel_d == 3'd0) begin
                                r_digits <= {r_work[23:4], w_dec};
                                r_cnt1   <= bcd_count(r_work[19:16], r_work[23:20]);
                                r_cnt2   <= bcd_count(r_work[7:4], r_work[11:8]);
                                r_state  <= S_PUBLISH;
                            end else begin
                                r_exp <= r_exp - 3'd1;
                            end
                        end else begin
                            r_err_seq <= 1'b1;
                            r_state   <= S_SYNC;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign digits      = r_digits;
    assign cnt1        = r_cnt1;
    assign cnt2        = r_cnt2;
    assign frame_valid = (r_state == S_PUBLISH);
    assign err_seq     = r_err_seq;
    assign err_pat     = r_err_pat;
endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Passive monitor that sits on the multiplexed 7-segment bus (`seg7_out`, `seg7_sel`) driven by the traffic-light top level. It samples each scanned digit, decodes the segment pattern back to BCD, and publishes a complete 6-digit frame once per full scan. From that frame it also reconstructs the two countdown values shown for light 1 and light 2. It is used for on-board self-check and as the display-side checker in system benches.

## Interface
Parameters:
- `STABLE_CYC`, default 4: number of consecutive `clk` cycles that `seg7_sel` and `seg7_out` must hold unchanged before a digit is captured. Legal range 2..255.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  reset; synchronous, active-high.
- `seg7_sel`  in  3  digit select being driven. Valid values 5..0; scan order is 5 (rightmost), 4, 3, 2, 1, 0, then wraps to 5.
- `seg7_out`  in  7  segment pattern, bit order abcdefg, active-high.
- `clr_err`  in  1  one-cycle pulse that clears the sticky error flags.
- `digits`  out  24  last published frame; `digits[4k+3:4k]` holds the digit captured at select k. 4'hF means blank, 4'hE means invalid pattern.
- `cnt1`  out  7  light-1 count in binary, from tens = sel 4 and ones = sel 5. 7'h7F means not decodable.
- `cnt2`  out  7  light-2 count in binary, from tens = sel 1 and ones = sel 2. 7'h7F means not decodable.
- `frame_valid`  out  1  one-cycle pulse when `digits`, `cnt1` and `cnt2` update.
- `err_seq`  out  1  sticky flag: select out of order or out of range.
- `err_pat`  out  1  sticky flag: an unrecognised segment pattern was captured.

## Operation
- Input stage: `seg7_sel` and `seg7_out` are registered once on entry. All further logic uses only these registered copies.
- Stability counter:
  - Resets to 0 whenever the registered sel or segments differ from their values in the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYC`.
  - A capture fires in the single cycle the counter reaches `STABLE_CYC`-1. This gives exactly one capture per dwell.
- Decode:
  - The 10 patterns 0..9 are 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - 0000000 decodes to 4'hF (blank).
  - Any other pattern decodes to 4'hE and sets `err_pat`.
- FSM states:
  - SYNC: wait for a capture with sel = 5. That capture stores the digit in the working buffer and moves the FSM to SCAN with expected = 4.
  - SCAN: on each capture, if sel = expected, store the digit and decrement expected. A capture of sel 0 moves the FSM to PUBLISH.
  - SCAN: a capture with any other sel, or any sel of 6 or 7 in any state, sets `err_seq` and returns the FSM to SYNC. The working buffer is discarded; the published outputs are left unchanged.
  - PUBLISH: a one-cycle state. It copies the working buffer to `digits`, loads `cnt1`/`cnt2`, pulses `frame_valid`, then goes to SYNC.
- Count arithmetic, shown for `cnt1` (`cnt2` is the same with sel 1 and sel 2):
  - Tens and ones both in 0..9: result is tens*10 + ones.
  - Tens blank and ones in 0..9: result is ones.
  - Anything else: result is 7'h7F.
  - Maximum legal result is 99, which fits in 7 bits.
- Selects 3 and 0 are captured and published but not used by the count logic.
- Sticky flags:
  - Cleared by `rst` or by `clr_err`.
  - If a set event and `clr_err` occur in the same cycle, the set wins.

## Timing
- Reset values (the block remains in reset while `rst` is high):
  - `digits` = 24'hFFFFFF, `cnt1` = `cnt2` = 7'h7F.
  - `frame_valid`, `err_seq`, `err_pat` = 0.
  - FSM in SYNC, stability counter at 0.
- Capture latency: the capture cycle is 1 cycle (input register) + `STABLE_CYC`-1 cycles after the first `clk` edge that samples a new sel/segment value.
- `frame_valid` asserts exactly 1 cycle after the sel-0 capture. `digits`, `cnt1` and `cnt2` change in that same cycle and hold until the next PUBLISH.
- A dwell shorter than `STABLE_CYC` cycles produces no capture. The next captured sel then mismatches expected, which sets `err_seq` and resyncs.
- `rst` asserted mid-frame: reset values apply on the next edge and the partial frame is lost. Capture resumes from SYNC once `rst` is released.
- A continuous hold on one value never produces a second capture.

## Configuration
- `SEG7_CAP_ACTIVE_LOW_EN` defined: registered `seg7_out` is inverted before decode, for common-anode panels (e.g. 0000001 decodes as 0, 1111111 as blank). All other behaviour is identical.
- `SEG7_CAP_ACTIVE_LOW_EN` undefined: active-high decode as listed under Operation.

## Test plan
- Nominal frame, `STABLE_CYC`=4. Scan sel 5..0 with 8-cycle dwells, patterns 9, 2, blank, 5, 1, blank. Expect: one `frame_valid` pulse, `digits`=24'h92F51F, `cnt1`=29, `cnt2`=15, both error flags 0.
- Single-digit count. Sel 4 blank and sel 5 = 7 (1110000). Expect: `cnt1`=7. With sel 4 = 3 and sel 5 blank, expect `cnt1`=7'h7F.
- Short dwell. Sel 4 held for 3 cycles, then sel 3. Expect: `err_seq`=1, no `frame_valid`, previous `digits` unchanged. The next clean 5..0 scan publishes normally.
- Bad pattern. Sel 2 = 1000000. Expect: the digit at sel 2 is 4'hE, `err_pat`=1, `cnt2`=7'h7F, and the frame still publishes. A `clr_err` pulse then returns `err_pat` to 0.
- Reset mid-frame. Assert `rst` for 1 cycle after the sel 3 capture. Expect: all outputs at reset values. The following full scan yields `frame_valid` with the correct digits.
- Macro build with `SEG7_CAP_ACTIVE_LOW_EN`. Drive the inverted nominal patterns. Expect: the same `digits`=24'h92F51F, `cnt1`=29, `cnt2`=15.
